mem_bridge: RTL and testbench

Bus bridge between the multicycle core's datapath memory port and an external word-addressed memory with valid/ready request and rvalid response channels. It sits directly downstream of the datapath's address/write-data mux, which currently drives the unified instruction/data memory. Per access it:
- aligns store data and generates byte strobes;
- sign- or zero-extends load data according to funct3;
- detects misaligned and illegal accesses and bus timeouts;
- holds `busy` so the control FSM stalls until a one-cycle `done`.

---
 rtl/mem_bridge_pkg.sv | 42 ++++
 rtl/mem_bridge_if.sv | 28 ++
 rtl/mem_lane_align.sv | 65 ++++++
 rtl/mem_bridge.sv | 190 +++++++++++++++++++
 tb/tb_mem_bridge.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types and constants for the memory bridge
//
// Purpose: FSM state encoding, RV32I load/store funct3 codes, fault cause
// codes, default timeout and small decode helpers used by mem_bridge.
// Ports: none (package).
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_RDATA = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  localparam int TIMEOUT_DEF = 255;

  // Stores only exist as sb/sh/sw; the unsigned codes are load-only.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    logic plain;
    plain = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
           (is_store && !plain);
  endfunction

  // funct3[1:0] encodes the access size for every legal code.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) ||
           ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// rtl/mem_bridge_if.sv - word-addressed memory request/response bus
//
// Purpose: groups the external memory channel of the bridge.
// Signals: m_valid/m_ready request handshake carrying m_we, m_addr,
// m_wstrb, m_wdata; m_rvalid/m_rdata read response (no back-pressure).
// Modports: master (bridge side), slave (memory side).
interface mem_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              m_valid;
  logic              m_ready;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_wstrb;
  logic [31:0]       m_wdata;
  logic              m_rvalid;
  logic [31:0]       m_rdata;

  modport master (
    output m_valid, m_we, m_addr, m_wstrb, m_wdata,
    input  m_ready, m_rvalid, m_rdata
  );

  modport slave (
    input  m_valid, m_we, m_addr, m_wstrb, m_wdata,
    output m_ready, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane alignment for stores and loads
//
// Purpose: purely combinational. Builds store strobes and lane-replicated
// store data, and extracts/extends the addressed byte or half of a read word.
// Ports:
//   funct3   in  3   load/store width and sign code
//   offset   in  2   byte offset within the word
//   st_data  in  32  unaligned store data (rs2)
//   ld_word  in  32  word returned by memory
//   st_strb  out 4   byte write strobes
//   st_word  out 32  replicated store data
//   ld_data  out 32  extended load result
module mem_lane_align
  import mem_bridge_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_strb,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_strb = 4'b1111;
    st_word = st_data;
    case (funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << offset;
        st_word = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << offset;
        st_word = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[7:0];
    case (offset)
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      2'd3:    ld_byte = ld_word[31:24];
      default: ;
    endcase
    // Halves are only ever fetched at offset 0 or 2 after the alignment check.
    ld_half = offset[1] ? ld_word[31:16] : ld_word[15:0];

    ld_data = ld_word;
    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - core datapath to external memory bus bridge
//
// Purpose: performs one load/store per req: alignment checks, store strobe
// generation, load extension, bus timeout, busy/done handshake to the core.
// Ports:
//   clk, reset            clock, async active-low reset
//   req, we, funct3,      access request and attributes, sampled in IDLE
//   addr, wdata
//   busy, done            stall indication and one-cycle completion pulse
//   rdata                 extended load data, kept until the next load
//   fault, fault_cause    failure flag/cause, valid with done
//   mem                   memory bus (mem_bridge_if master)
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic [1:0]        fault_cause,
  mem_bridge_if.master      mem
);

  // Last cycle index before the budget of TIMEOUT cycles is spent.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              m_valid_q, m_valid_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [3:0]        m_wstrb_q, m_wstrb_d;
  logic [31:0]       m_wdata_q, m_wdata_d;

  logic [1:0]        fin_cause;
  logic [2:0]        al_f3;
  logic [1:0]        al_off;
  logic [3:0]        al_strb;
  logic [31:0]       al_word;
  logic [31:0]       al_ld;

  // In IDLE the aligner prepares the store from the live request; afterwards
  // it extracts the load using the latched attributes.
  assign al_f3  = (state_q == ST_IDLE) ? funct3    : f3_q;
  assign al_off = (state_q == ST_IDLE) ? addr[1:0] : off_q;

  mem_lane_align u_align (
    .funct3  (al_f3),
    .offset  (al_off),
    .st_data (wdata),
    .ld_word (mem.m_rdata),
    .st_strb (al_strb),
    .st_word (al_word),
    .ld_data (al_ld)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wstrb_d = m_wstrb_q;
    m_wdata_d = m_wdata_q;
    fin_cause = CAUSE_NONE;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          f3_d  = funct3;
          off_d = addr[1:0];
          if (f3_illegal(funct3, we)) begin
            state_d   = ST_DONE;
            fin_cause = CAUSE_ILLEGAL;
          end else if (f3_misaligned(funct3, addr[1:0])) begin
            state_d   = ST_DONE;
            fin_cause = CAUSE_MISALGN;
          end else begin
            state_d   = ST_ADDR;
            cnt_d     = 8'd0;
            m_we_d    = we;
            m_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            m_wstrb_d = we ? al_strb : 4'b0000;
            m_wdata_d = we ? al_word : 32'd0;
          end
        end
      end

      ST_ADDR: begin
        cnt_d = cnt_q + 8'd1;
        // A handshake in the final budget cycle still completes the request.
        if (mem.m_ready) begin
          state_d = m_we_q ? ST_DONE : ST_RDATA;
        end else if (cnt_q >= TO_LAST) begin
          state_d   = ST_DONE;
          fin_cause = CAUSE_TIMEOUT;
        end
      end

      ST_RDATA: begin
        cnt_d = cnt_q + 8'd1;
        if (mem.m_rvalid) begin
          state_d = ST_DONE;
          rdata_d = al_ld;
        end else if (cnt_q >= TO_LAST) begin
          state_d   = ST_DONE;
          fin_cause = CAUSE_TIMEOUT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    busy_d    = (state_d != ST_IDLE);
    m_valid_d = (state_d == ST_ADDR);
    done_d    = (state_d == ST_DONE);
    cause_d   = done_d ? fin_cause : CAUSE_NONE;
    fault_d   = done_d && (fin_cause != CAUSE_NONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= CAUSE_NONE;
      rdata_q   <= 32'd0;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wstrb_q <= 4'd0;
      m_wdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
      rdata_q   <= rdata_d;
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wstrb_q <= m_wstrb_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign rdata       = rdata_q;
  assign mem.m_valid = m_valid_q;
  assign mem.m_we    = m_we_q;
  assign mem.m_addr  = m_addr_q;
  assign mem.m_wstrb = m_wstrb_q;
  assign mem.m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - self-checking bench for mem_bridge
module tb_mem_bridge;
  import mem_bridge_pkg::*;

  localparam int TO = 255;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [1:0]  fault_cause;

  int          checks;
  int          errors;
  logic [31:0] last_rdata;

  mem_bridge_if #(.ADDR_W(32)) bus ();

  mem_bridge #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .fault       (fault),
    .fault_cause (fault_cause),
    .mem         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the access rules: size in bytes, offset
  // arithmetic, lane replication by modulo and mask-based extension.
  function automatic void model(input logic we_i, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rw, output logic [1:0] cause,
                                output logic [3:0] strb, output logic [31:0] wword,
                                output logic [31:0] ext);
    int size;
    int k;
    logic [31:0] mask;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    k = int'(a % 4);
    cause = 2'b00;
    if (f3 == 3 || f3 == 6 || f3 == 7 || (we_i && f3 > 2)) cause = 2'b11;
    else if ((a % size) != 0) cause = 2'b01;
    strb = we_i ? 4'(((1 << size) - 1) << k) : 4'b0000;
    for (int i = 0; i < 4; i++) wword[8*i +: 8] = wd[8*(i % size) +: 8];
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    v = (rw >> (8 * k)) & mask;
    if (size < 4 && !f3[2] && v[8*size-1]) v = v | ~mask;
    ext = v;
  endfunction

  // One access: rl = cycles m_valid is seen before m_ready is given
  // (>= TO means never), rvl = cycles after the handshake before m_rvalid.
  task automatic run(input logic we_i, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rw, input int rl,
                     input int rvl);
    logic [1:0]  e_cause;
    logic [3:0]  e_strb;
    logic [31:0] e_wword, e_ext, e_rd;
    int          e_cyc, e_mv;
    int          done_cyc, mv, hs;
    logic        st_ok;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_strb;
    logic        c_we;
    logic        o_fault;
    logic [1:0]  o_cause;
    logic [31:0] o_rdata;

    model(we_i, f3, a, wd, rw, e_cause, e_strb, e_wword, e_ext);
    e_rd = last_rdata;
    if (e_cause != 2'b00) begin
      e_cyc = 1; e_mv = 0;
    end else if (rl >= TO) begin
      e_cause = 2'b10; e_cyc = TO + 1; e_mv = TO;
    end else if (we_i) begin
      e_cyc = rl + 2; e_mv = rl + 1;
    end else begin
      e_cyc = rl + rvl + 3; e_mv = rl + 1; e_rd = e_ext;
    end

    done_cyc = -1; mv = 0; hs = 0; st_ok = 1'b1;
    c_addr = '0; c_wdata = '0; c_strb = '0; c_we = 1'b0;
    o_fault = 1'b0; o_cause = 2'b00; o_rdata = '0;

    @(negedge clk);
    req = 1'b1; we = we_i; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = $urandom; wdata = $urandom;
    for (int n = 1; n <= TO + 20; n++) begin
      if (n > 1) @(negedge clk);
      bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = $urandom;
      if (done === 1'b1) begin
        done_cyc = n; o_fault = fault; o_cause = fault_cause; o_rdata = rdata;
        break;
      end
      if (bus.m_valid === 1'b1) begin
        if (mv == 0) begin
          c_addr = bus.m_addr; c_wdata = bus.m_wdata; c_strb = bus.m_wstrb; c_we = bus.m_we;
        end else if (c_addr !== bus.m_addr || c_wdata !== bus.m_wdata ||
                     c_strb !== bus.m_wstrb || c_we !== bus.m_we) begin
          st_ok = 1'b0;
        end
        if (mv == rl) begin
          bus.m_ready = 1'b1; hs = n;
        end
        mv++;
      end else if (hs > 0 && !we_i && (n - hs - 1) == rvl) begin
        bus.m_rvalid = 1'b1; bus.m_rdata = rw;
      end
    end

    check("done_cycle", 32'(done_cyc), 32'(e_cyc));
    check("fault", 32'(o_fault), 32'(e_cause != 2'b00));
    check("fault_cause", 32'(o_cause), 32'(e_cause));
    check("valid_cycles", 32'(mv), 32'(e_mv));
    check("rdata_at_done", o_rdata, e_rd);
    if (e_mv > 0) begin
      check("m_addr", c_addr, {a[31:2], 2'b00});
      check("m_we", 32'(c_we), 32'(we_i));
      check("m_wstrb", 32'(c_strb), 32'(e_strb));
      if (we_i) check("m_wdata", c_wdata, e_wword);
      check("req_stable", 32'(st_ok), 32'd1);
    end

    // A legal req in the DONE cycle must be ignored; stray m_rvalid after
    // completion must not disturb rdata.
    req = 1'b1; we = 1'b0; funct3 = F3_W; addr = $urandom & 32'hFFFF_FFFC;
    bus.m_rvalid = 1'b1; bus.m_rdata = $urandom;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(bus.m_valid), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
    req = 1'b0; bus.m_rdata = $urandom;
    @(negedge clk);
    bus.m_rvalid = 1'b0;
    check("rdata_hold", rdata, e_rd);
    last_rdata = e_rd;
  endtask

  initial begin
    checks = 0; errors = 0; last_rdata = 32'd0;
    reset = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
    bus.m_ready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_fault", {30'd0, done, fault}, 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_valid_we", {30'd0, bus.m_valid, bus.m_we}, 32'd0);
    check("rst_addr", bus.m_addr, 32'd0);
    check("rst_strb", 32'(bus.m_wstrb), 32'd0);
    check("rst_wdata", bus.m_wdata, 32'd0);
    reset = 1'b1;

    run(1'b0, F3_W,  32'h20, 32'h0, 32'hDEADBEEF, 0, 0);
    run(1'b0, F3_B,  32'h23, 32'h0, 32'h80FF0102, 0, 0);
    run(1'b0, F3_BU, 32'h23, 32'h0, 32'h80FF0102, 0, 0);
    run(1'b0, F3_HU, 32'h22, 32'h0, 32'h80FF0102, 0, 0);
    run(1'b0, F3_H,  32'h22, 32'h0, 32'h80FF0102, 1, 2);
    run(1'b1, F3_B,  32'h21, 32'h123456AB, 32'h0, 4, 0);
    run(1'b1, F3_H,  32'h2A, 32'h9876CAFE, 32'h0, 0, 0);
    run(1'b1, F3_W,  32'h2C, 32'h01234567, 32'h0, 2, 0);
    run(1'b0, F3_W,  32'h22, 32'h0, 32'h11111111, 0, 0);
    run(1'b0, 3'b011, 32'h20, 32'h0, 32'h22222222, 0, 0);
    run(1'b1, F3_BU, 32'h20, 32'h55, 32'h0, 0, 0);
    run(1'b0, F3_W,  32'h30, 32'h0, 32'h33333333, TO + 100, 0);

    // Reset while a request is pending on the bus.
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h40;
    @(negedge clk);
    req = 1'b0;
    check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_addr_valid", 32'(bus.m_valid), 32'd0);
    check("rst_addr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    last_rdata = 32'd0;

    // Reset while waiting for read data.
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h44;
    @(negedge clk);
    req = 1'b0; bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_rd_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(bus.m_valid), 32'd0);
    check("rst_rd_rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    last_rdata = 32'd0;
    run(1'b0, F3_W, 32'h48, 32'h0, 32'h13579BDF, 0, 0);

    for (int t = 0; t < 40; t++) begin
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          32'h100 + 32'($urandom_range(0, 63)), $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
